controlador_entrada: RTL and testbench

//  Front-end for the user-input instruction. Synchronises and debounces the raw "ent" pushbutton,

---
 rtl/controlador_entrada_pkg.sv | 20 ++
 rtl/controlador_entrada_filtro_debounce.sv | 76 +++++++
 rtl/controlador_entrada.sv | 133 +++++++++++++
 tb/tb_controlador_entrada.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/controlador_entrada_pkg.sv
// Shared definitions for the user-input front-end.
//  - FSM state encodings (2-bit, legacy-compatible localparams)
//  - default debounce length for the 50 MHz board clock
//  - bit positions inside the synchronised control/data bundle used by the top
package controlador_entrada_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_PRESSED = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  // 10 ms at 50 MHz
  localparam int DEBOUNCE_CYCLES_DEF = 500000;

  // Layout of the bundle fed through the top-level synchroniser:
  // bit CTRL_REQ is req, bits CTRL_SW_LSB and up are the switches.
  localparam int CTRL_REQ    = 0;
  localparam int CTRL_SW_LSB = 1;

endpackage

// File: rtl/controlador_entrada_filtro_debounce.sv
// filtro_debounce: 2-FF synchroniser and stability counter for the active-low key.
//  clk           in   board clock
//  reset         in   asynchronous, active-low
//  raw_n         in   raw pushbutton, active-low, asynchronous
//  state         out  debounced key level (1 = pressed)
//  press_evt     out  one-cycle pulse on the 0->1 edge of state
//  release_evt   out  one-cycle pulse on the 1->0 edge of state
//  pressed_sync  out  synchronised (not debounced) key level, 1 = pressed;
//                     lets the controller spot a key that is already down
//                     before the debouncer has accepted it
module filtro_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_n,
  output logic state,
  output logic press_evt,
  output logic release_evt,
  output logic pressed_sync
);

  // Synchroniser resets to "released".
  logic key_s1_q, key_s2_q;
  logic pressed_s;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             state_q, state_d;
  logic             state_prev_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_s1_q <= 1'b1;
      key_s2_q <= 1'b1;
    end else begin
      key_s1_q <= raw_n;
      key_s2_q <= key_s1_q;
    end
  end

  assign pressed_s = ~key_s2_q;

  // Counter only runs while the synced level disagrees with the accepted
  // state; any return to agreement throws the partial count away.
  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    if (pressed_s == state_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      state_d = pressed_s;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q        <= '0;
      state_q      <= 1'b0;
      state_prev_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      state_prev_q <= state_q;
    end
  end

  assign state        = state_q;
  assign press_evt    = state_q & ~state_prev_q;
  assign release_evt  = ~state_q & state_prev_q;
  assign pressed_sync = pressed_s;

endmodule

// File: rtl/controlador_entrada.sv
// controlador_entrada: debounced "ent" key + switch capture, handed to the
// processor over a 4-phase req/valid handshake.
//  clk        in   board clock
//  reset      in   asynchronous, active-low
//  key_n      in   raw pushbutton, active-low, asynchronous
//  switch_in  in   [DATA_W] raw switches, asynchronous
//  req        in   processor request level (slow clock domain)
//  valid      out  data_out holds a captured word; held until req falls
//  data_out   out  [DATA_W] captured switch word
//  key_state  out  debounced key level for the LED
module controlador_entrada
  import controlador_entrada_pkg::*;
#(
  parameter int DATA_W          = 16,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_n,
  input  logic [DATA_W-1:0] switch_in,
  input  logic              req,
  output logic              valid,
  output logic [DATA_W-1:0] data_out,
  output logic              key_state
);

  localparam int BUN_W = DATA_W + 1;

  // req and switches share one 2-FF synchroniser bundle.
  logic [BUN_W-1:0] bun_raw, bun_s1_q, bun_s2_q;
  logic             req_s;
  logic [DATA_W-1:0] sw_s;

  assign bun_raw[CTRL_REQ]                       = req;
  assign bun_raw[CTRL_SW_LSB +: DATA_W]          = switch_in;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bun_s1_q <= '0;
      bun_s2_q <= '0;
    end else begin
      bun_s1_q <= bun_raw;
      bun_s2_q <= bun_s1_q;
    end
  end

  assign req_s = bun_s2_q[CTRL_REQ];
  assign sw_s  = bun_s2_q[CTRL_SW_LSB +: DATA_W];

  logic key_st, press_evt, release_evt, pressed_sync;

  filtro_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_deb (
    .clk          (clk),
    .reset        (reset),
    .raw_n        (key_n),
    .state        (key_st),
    .press_evt    (press_evt),
    .release_evt  (release_evt),
    .pressed_sync (pressed_sync)
  );

  logic [1:0]        state_q, state_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q,  data_d;
  // hold_q: the key was already down (debounced or not) when ARMED was
  // entered; its press must not count until the key has gone fully up.
  logic              hold_q,  hold_d;

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    data_d  = data_q;
    hold_d  = hold_q;
    case (state_q)
      ST_IDLE: begin
        valid_d = 1'b0;
        hold_d  = key_st | pressed_sync;
        if (req_s) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        hold_d = hold_q & (key_st | pressed_sync);
        // Abort has priority over a simultaneous press.
        if (!req_s) begin
          state_d = ST_IDLE;
        end else if (press_evt && !hold_q) begin
          data_d  = sw_s;
          state_d = ST_PRESSED;
        end
      end
      ST_PRESSED: begin
        if (!req_s) begin
          state_d = ST_IDLE;
        end else if (release_evt) begin
          state_d = ST_DONE;
          valid_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (!req_s) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      data_q  <= '0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      hold_q  <= hold_d;
    end
  end

  assign valid     = valid_q;
  assign data_out  = data_q;
  assign key_state = key_st;

endmodule

// File: tb/tb_controlador_entrada.sv
module tb_controlador_entrada;

  logic        clk = 1'b0;
  logic        reset;
  logic        key_n;
  logic [15:0] switch_in;
  logic        req;
  logic        valid;
  logic [15:0] data_out;
  logic        key_state;

  int n_chk  = 0;
  int n_fail = 0;

  // Rising edges of key_state (= press events), tracked by a monitor.
  int  press_cnt = 0;
  logic ks_prev  = 1'b0;

  always #5 clk = ~clk;

  controlador_entrada #(
    .DATA_W          (16),
    .DEBOUNCE_CYCLES (8),
    .CNT_W           (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .key_n     (key_n),
    .switch_in (switch_in),
    .req       (req),
    .valid     (valid),
    .data_out  (data_out),
    .key_state (key_state)
  );

  always @(negedge clk) begin
    if (key_state === 1'b1 && ks_prev === 1'b0) press_cnt++;
    ks_prev = key_state;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  int p0;

  initial begin
    // 1: reset with key held and req high
    reset = 1'b0; key_n = 1'b0; req = 1'b1; switch_in = 16'hDEAD;
    tick(5);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_data", {16'd0, data_out}, 32'd0);
    chk("rst_key", {31'd0, key_state}, 32'd0);
    reset = 1'b1;
    tick(20);
    chk("t1_key_held", {31'd0, key_state}, 32'd1);
    chk("t1_no_capture", {16'd0, data_out}, 32'd0);
    chk("t1_no_valid", {31'd0, valid}, 32'd0);
    key_n = 1'b1;
    tick(12);
    chk("t1_key_rel", {31'd0, key_state}, 32'd0);
    chk("t1_still_empty", {16'd0, data_out}, 32'd0);

    // 2: clean transaction (still ARMED, req high)
    switch_in = 16'hA5C3;
    tick(3);
    key_n = 1'b0;
    tick(20);
    chk("t2_data", {16'd0, data_out}, 32'h0000A5C3);
    chk("t2_valid_pre", {31'd0, valid}, 32'd0);
    key_n = 1'b1;
    tick(10);  // 2 sync + 8 debounce: release_evt just raised
    chk("t2_valid_at10", {31'd0, valid}, 32'd0);
    tick(1);
    chk("t2_valid_at11", {31'd0, valid}, 32'd1);
    chk("t2_data_hold", {16'd0, data_out}, 32'h0000A5C3);
    req = 1'b0;
    tick(3);
    chk("t2_valid_drop", {31'd0, valid}, 32'd0);

    // 3: bounce
    req = 1'b1; switch_in = 16'h3C3C;
    tick(4);
    p0 = press_cnt;
    for (int i = 0; i < 10; i++) begin
      key_n = ~key_n;
      tick(3);
      chk("t3_bounce_key", {31'd0, key_state}, 32'd0);
      chk("t3_bounce_data", {16'd0, data_out}, 32'h0000A5C3);
    end
    key_n = 1'b0;
    tick(9);
    chk("t3_key_at9", {31'd0, key_state}, 32'd0);
    tick(1);
    chk("t3_key_at10", {31'd0, key_state}, 32'd1);
    chk("t3_data_at10", {16'd0, data_out}, 32'h0000A5C3);
    tick(1);
    chk("t3_data_at11", {16'd0, data_out}, 32'h00003C3C);
    tick(2);
    chk("t3_one_press", press_cnt - p0, 32'd1);
    key_n = 1'b1;
    tick(11);
    chk("t3_valid", {31'd0, valid}, 32'd1);
    req = 1'b0;
    tick(3);
    chk("t3_valid_drop", {31'd0, valid}, 32'd0);

    // 4: key already held when ARMED is entered
    key_n = 1'b0;
    tick(12);
    switch_in = 16'h9999;
    req = 1'b1;
    tick(15);
    chk("t4_no_capture", {16'd0, data_out}, 32'h00003C3C);
    chk("t4_no_valid", {31'd0, valid}, 32'd0);
    key_n = 1'b1;
    tick(12);
    switch_in = 16'h0042;
    tick(3);
    key_n = 1'b0;
    tick(12);
    chk("t4_data", {16'd0, data_out}, 32'h00000042);
    key_n = 1'b1;
    tick(11);
    chk("t4_valid", {31'd0, valid}, 32'd1);
    req = 1'b0;
    tick(3);

    // 5: abort before release
    req = 1'b1; switch_in = 16'h1234;
    tick(4);
    key_n = 1'b0;
    tick(12);
    chk("t5_data_new", {16'd0, data_out}, 32'h00001234);
    req = 1'b0;
    tick(4);
    key_n = 1'b1;
    tick(12);
    chk("t5_aborted_valid", {31'd0, valid}, 32'd0);
    chk("t5_data_kept", {16'd0, data_out}, 32'h00001234);
    req = 1'b1; switch_in = 16'h5678;
    tick(4);
    key_n = 1'b0;
    tick(12);
    key_n = 1'b1;
    tick(11);
    chk("t5_valid", {31'd0, valid}, 32'd1);
    chk("t5_data", {16'd0, data_out}, 32'h00005678);

    // 6: freeze in DONE
    switch_in = 16'hFFFF;
    tick(4);
    switch_in = 16'h0000;
    tick(4);
    key_n = 1'b0;
    tick(12);
    key_n = 1'b1;
    tick(12);
    chk("t6_data_frozen", {16'd0, data_out}, 32'h00005678);
    chk("t6_valid_held", {31'd0, valid}, 32'd1);
    req = 1'b0;
    tick(2);
    chk("t6_valid_at2", {31'd0, valid}, 32'd1);
    tick(1);
    chk("t6_valid_at3", {31'd0, valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
